// File: rtl/onehot_monitor_pkg.sv
// Shared types and constants for the onehot_monitor block (package onehot_pkg).
package onehot_pkg;

  typedef enum logic {
    CLEAN,
    FAULT
  } mon_state_e;

  typedef enum logic [1:0] {
    ZERO,
    ONE,
    MULTI
  } vec_class_e;

  localparam logic MODE_AT_MOST_ONE = 1'b0;
  localparam logic MODE_EXACTLY_ONE = 1'b1;

endpackage : onehot_pkg

// File: rtl/onehot_monitor_if.sv
// Sample/result bundle for onehot_monitor. first_bad exists only when
// ONEHOT_MON_CAPTURE_EN is defined.
interface onehot_monitor_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = $clog2(N)
);
  logic             in_valid;
  logic [N-1:0]     in_vec;
  logic             mode;
  logic             clr;
  logic             ok_valid;
  logic             ok;
  logic [IDX_W-1:0] idx;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
`ifdef ONEHOT_MON_CAPTURE_EN
  logic [N-1:0]     first_bad;

  modport master (
    output in_valid, in_vec, mode, clr,
    input  ok_valid, ok, idx, err_sticky, err_cnt, first_bad
  );

  modport slave (
    input  in_valid, in_vec, mode, clr,
    output ok_valid, ok, idx, err_sticky, err_cnt, first_bad
  );
`else
  modport master (
    output in_valid, in_vec, mode, clr,
    input  ok_valid, ok, idx, err_sticky, err_cnt
  );

  modport slave (
    input  in_valid, in_vec, mode, clr,
    output ok_valid, ok, idx, err_sticky, err_cnt
  );
`endif

endinterface : onehot_monitor_if

// File: rtl/onehot_classify.sv
// Combinational classifier: ZERO / ONE / MULTI plus encoded index of the
// single set bit (0 unless the vector is one-hot).
module onehot_classify
  import onehot_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output vec_class_e       cls_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [1:0]       ones;
  logic [IDX_W-1:0] pos;

  // Saturating popcount (0, 1, 2+) and position of the last set bit.
  always_comb begin
    ones = '0;
    pos  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        if (ones != 2'd2) ones = ones + 2'd1;
        pos = IDX_W'(i);
      end
    end
    cls_o = MULTI;
    idx_o = '0;
    if (ones == 2'd0) begin
      cls_o = ZERO;
    end else if (ones == 2'd1) begin
      cls_o = ONE;
      idx_o = pos;
    end
  end

endmodule : onehot_classify

// File: rtl/onehot_monitor.sv
// Registered at-most-one / exactly-one hot monitor with sticky fault state,
// saturating violation counter and optional first-offender capture
// (compiled in with ONEHOT_MON_CAPTURE_EN).
module onehot_monitor
  import onehot_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input logic              clk,
  input logic              rst_n,
  onehot_monitor_if.slave  bus
);

  vec_class_e       cls;
  logic [IDX_W-1:0] cls_idx;
  logic             viol;

  mon_state_e       state_q, state_d;
  logic             ok_valid_q, ok_valid_d;
  logic             ok_q, ok_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  onehot_classify #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_classify (
    .vec_i (bus.in_vec),
    .cls_o (cls),
    .idx_o (cls_idx)
  );

  // Next state, counter and result registers; a violation overrides clr.
  always_comb begin
    viol       = bus.in_valid &
                 ((cls == MULTI) | ((cls == ZERO) & (bus.mode == MODE_EXACTLY_ONE)));
    state_d    = state_q;
    cnt_d      = cnt_q;
    ok_valid_d = bus.in_valid;
    ok_d       = ok_q;
    idx_d      = idx_q;

    case (state_q)
      CLEAN:   if (viol) state_d = FAULT;
      FAULT:   if (bus.clr && !viol) state_d = CLEAN;
      default: state_d = CLEAN;
    endcase

    if (viol) begin
      if (bus.clr)          cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.clr) begin
      cnt_d = '0;
    end

    if (bus.in_valid) begin
      ok_d  = ~viol;
      idx_d = (cls == ONE) ? cls_idx : '0;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAN;
      ok_valid_q <= 1'b0;
      ok_q       <= 1'b1;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ok_valid_q <= ok_valid_d;
      ok_q       <= ok_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ok_valid   = ok_valid_q;
  assign bus.ok         = ok_q;
  assign bus.idx        = idx_q;
  assign bus.err_sticky = (state_q == FAULT);
  assign bus.err_cnt    = cnt_q;

`ifdef ONEHOT_MON_CAPTURE_EN
  logic [N-1:0] first_bad_q, first_bad_d;

  // Capture on the first violation out of CLEAN, or on a violation that
  // coincides with clr (the clear restarts the capture window).
  always_comb begin
    first_bad_d = first_bad_q;
    if (viol && (bus.clr || state_q == CLEAN)) first_bad_d = bus.in_vec;
    else if (bus.clr)                          first_bad_d = '0;
  end

  // First-offender register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_bad_q <= '0;
    else        first_bad_q <= first_bad_d;
  end

  assign bus.first_bad = first_bad_q;
`endif

endmodule : onehot_monitor
